// File: rtl/apb_pkg.sv
// Shared APB definitions: data width, completer FSM states and address helpers.
package apb_pkg;

  localparam int APB_DATA_W = 32;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_slv_state_e;

  // Word index of a byte address (drops the two byte-lane bits).
  function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
    return 30'(byte_addr >> 2);
  endfunction

endpackage

// File: rtl/apb_slv_regs.sv
// Register storage for the APB completer: constant ID word at index 0,
// read/write words above it, and a one-cycle commit pulse per word.
module apb_slv_regs
  import apb_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hA0B0_0001,
  parameter int          IDX_W    = 3
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [APB_DATA_W-1:0]          wr_data,
  output logic [APB_DATA_W*NUM_REGS-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  logic [APB_DATA_W-1:0] words [1:NUM_REGS-1];

  // Writable words: cleared on reset, loaded on a committed write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        words[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          words[i] <= wr_data;
        end
      end
    end
  end

  // Commit pulse appears the cycle after the word is written.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_pulse[i] <= wr_en && (wr_idx == IDX_W'(i));
      end
    end
  end

  assign reg_q[0 +: APB_DATA_W] = ID_VALUE;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_word
    assign reg_q[g*APB_DATA_W +: APB_DATA_W] = words[g];
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer with a read-only ID word, RW words, configurable access-phase
// wait states and PSLVERR on illegal accesses.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA0B0_0001
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           psel,
  input  logic                           penable,
  input  logic [31:0]                    paddr,
  input  logic                           pwrite,
  input  logic [APB_DATA_W-1:0]          pwdata,
  output logic [APB_DATA_W-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [APB_DATA_W*NUM_REGS-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);

  apb_slv_state_e        state_q, state_d;
  logic [3:0]            cnt_q;
  logic                  err_q;
  logic                  pwrite_q;
  logic [IDX_W-1:0]      idx_q;
  logic [APB_DATA_W-1:0] pwdata_q;

  logic [29:0]           idx_full;
  logic [IDX_W-1:0]      setup_idx;
  logic                  setup_err;
  logic [APB_DATA_W-1:0] rd_word;
  logic                  setup;
  logic                  complete;
  logic                  wr_en;

  assign idx_full  = word_index(paddr);
  assign setup_idx = idx_full[IDX_W-1:0];
  assign setup_err = (paddr[1:0] != 2'b00)
                   | (paddr[31:ADDR_W] != '0)
                   | (idx_full >= 30'(NUM_REGS))
                   | (pwrite && (idx_full == 30'd0));

  // Read mux selecting the addressed word during the setup phase.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (setup_idx == IDX_W'(i)) begin
        rd_word = reg_q[i*APB_DATA_W +: APB_DATA_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake decode and transfer events.
  always_comb begin
    state_d  = state_q;
    setup    = 1'b0;
    complete = 1'b0;
    pready   = (state_q == ACCESS) && (cnt_q == 4'd0);
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          setup   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable && pready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pslverr = pready && err_q;
  assign wr_en   = complete && pwrite_q && !err_q;

  // Setup-phase capture of the request, wait countdown and registered read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      err_q    <= 1'b0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
      pwdata_q <= '0;
      prdata   <= '0;
    end else if (setup) begin
      cnt_q    <= 4'(WAIT_CYCLES);
      err_q    <= setup_err;
      pwrite_q <= pwrite;
      idx_q    <= setup_idx;
      pwdata_q <= pwdata;
      prdata   <= (!pwrite && !setup_err) ? rd_word : '0;
    end else if ((state_q == ACCESS) && psel && penable && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  apb_slv_regs #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE),
    .IDX_W    (IDX_W)
  ) u_regs (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_data  (pwdata_q),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

endmodule
